// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serial transmitter fed by a frame FIFO; data bits change on bck falling edges.
// A frame pops at frame bit 0; s_ready drops when the FIFO is full; an empty FIFO sends silence and flags underrun.

module i2s_tdm_tx #(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int BCK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       mode,
    input  logic                       mute,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] s_data,
    output logic                       bck,
    output logic                       ws,
    output logic                       sdata,
    output logic                       frame_start,
    output logic                       underrun
);

    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int TOT     = NUM_CH * SLOT_W;
    localparam int IDX_W   = $clog2(TOT);
    localparam int OFF_W   = $clog2(SLOT_W);
    localparam int SL_W    = $clog2(NUM_CH);
    localparam int DIV_W   = $clog2(BCK_DIV);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(BCK_DIV / 2);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(TOT - 1);
    localparam logic [IDX_W-1:0] IDX_SLOT    = IDX_W'(SLOT_W);
    localparam logic [IDX_W-1:0] IDX_SLOT_M1 = IDX_W'(SLOT_W - 1);
    localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(SLOT_W - 1);
    localparam logic [PTR_W:0]   CNT_FULL    = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [OFF_W-1:0]   r_off;
    logic [SL_W-1:0]    r_slot;
    logic [FRAME_W-1:0] r_frame;
    logic               r_mode;
    logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr;
    logic [PTR_W-1:0]   r_rd;
    logic [PTR_W:0]     r_cnt;

    logic               w_fall;
    logic               w_pop_pt;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [PTR_W:0]     w_cnt_nxt;
    logic [FRAME_W-1:0] w_frame;
    logic               w_mode;
    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W-1:0] w_sh;
    int                 w_pos;
    logic               w_bit;
    logic               w_ws;

    assign w_fall    = en && (r_div == DIV_LAST);
    assign w_div_nxt = w_fall ? '0 : r_div + 1'b1;
    assign w_pop_pt  = w_fall && (r_bit_idx == '0);
    assign w_empty   = (r_cnt == '0);
    assign w_pop     = w_pop_pt && !w_empty;
    assign w_push    = s_valid && s_ready;
    assign w_cnt_nxt = r_cnt + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

    // At the pop point the bit being driven already belongs to the new frame.
    assign w_frame  = !w_pop_pt ? r_frame : ((mute || w_empty) ? '0 : r_mem[r_rd]);
    assign w_mode   = w_pop_pt ? mode : r_mode;
    assign w_sample = w_frame[int'(r_slot) * SAMPLE_W +: SAMPLE_W];

    always_comb begin
        w_pos = int'(r_off) - (w_mode ? 0 : 1);
        w_sh  = '0;
        w_bit = 1'b0;
        if (w_pos >= 0 && w_pos < SAMPLE_W) begin
            w_sh  = w_sample << w_pos;
            w_bit = w_sh[SAMPLE_W-1];
        end
    end

    // I2S leads the LJ word-select pattern by one bit, wrapping into the next frame.
    always_comb begin
        w_ws = 1'b0;
        if (NUM_CH == 2)
            w_ws = w_mode ? (r_bit_idx >= IDX_SLOT)
                          : (r_bit_idx >= IDX_SLOT_M1 && r_bit_idx != IDX_LAST);
        else
            w_ws = w_mode ? (r_bit_idx == '0) : (r_bit_idx == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_bit_idx   <= '0;
            r_off       <= '0;
            r_slot      <= '0;
            r_frame     <= '0;
            r_mode      <= 1'b0;
            bck         <= 1'b0;
            ws          <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (!en) begin
                r_div     <= '0;
                r_bit_idx <= '0;
                r_off     <= '0;
                r_slot    <= '0;
                bck       <= 1'b0;
                ws        <= 1'b0;
                sdata     <= 1'b0;
            end else begin
                r_div <= w_div_nxt;
                bck   <= (w_div_nxt >= DIV_HALF);
                if (w_fall) begin
                    ws    <= w_ws;
                    sdata <= w_bit;
                    if (w_pop_pt) begin
                        r_frame     <= w_frame;
                        r_mode      <= w_mode;
                        frame_start <= 1'b1;
                        underrun    <= w_empty;
                    end
                    r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : r_bit_idx + 1'b1;
                    if (r_off == OFF_LAST) begin
                        r_off  <= '0;
                        r_slot <= (r_bit_idx == IDX_LAST) ? '0 : r_slot + 1'b1;
                    end else begin
                        r_off <= r_off + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            s_ready <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_cnt   <= w_cnt_nxt;
            s_ready <= (w_cnt_nxt != CNT_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= s_data;
    end

endmodule

// File: doc/i2s_tdm_tx.md
I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, audio sample width in bits (8..32).
REQ-002 SHALL have parameter SLOT_W, default 32, bck cycles per channel slot; SLOT_W >= SAMPLE_W+1.
REQ-003 SHALL have parameter NUM_CH, default 2, channels per frame (2, 4, 6 or 8).
REQ-004 SHALL have parameter BCK_DIV, default 4, clk cycles per bck period (even, >=2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, frames buffered (power of 2, >=2).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-007 SHALL have en  in  1  transmit enable.
REQ-008 SHALL have mode  in  1  0 = I2S (1-bit delay), 1 = left-justified.
REQ-009 SHALL have mute  in  1  force zero samples.
REQ-010 SHALL have s_valid  in  1, s_ready  out  1, and s_data  in  NUM_CH*SAMPLE_W, carrying one frame with ch0 in the LSBs and each sample two's-complement.
REQ-011 SHALL have bck  out  1, ws  out  1, and sdata  out  1.
REQ-012 SHALL have frame_start  out  1 (1-clk pulse) and underrun  out  1 (1-clk pulse).

Function
REQ-013 SHALL register all outputs in the clk domain; bck is a divided clock-enable-derived output, not a clock net.
REQ-014 SHALL run div_cnt 0..BCK_DIV-1 while en=1; bck=0 for div_cnt < BCK_DIV/2, else 1.
REQ-015 SHALL define a falling edge as the clk where div_cnt wraps to 0; bit_idx (0..NUM_CH*SLOT_W-1) advances, and ws and sdata update, only on falling edges.
REQ-016 SHALL accept a frame into the FIFO when s_valid && s_ready; s_ready = !full, registered.
REQ-017 SHALL pop one frame on the falling edge with bit_idx=0 and pulse frame_start on that clk.
REQ-018 SHALL, if the FIFO is empty at the pop point, transmit an all-zero frame and pulse underrun.
REQ-019 SHALL sample mute at the pop point; a muted frame transmits zeros but still pops, and a mute change mid-frame takes effect next frame.
REQ-020 SHALL, for slot k at offset b (0..SLOT_W-1), drive sample bit SAMPLE_W-1-(b-d), MSB first, where d=1 in I2S mode and d=0 in LJ mode; all other offsets drive 0.
REQ-021 SHALL, when NUM_CH=2 and in LJ mode, drive ws=0 for slot 0 and ws=1 for slot 1; in I2S mode, ws changes one bck earlier.
REQ-022 SHALL, when NUM_CH>2, drive ws high for one bck at frame bit 0 (LJ) or at the last bit of the previous frame (I2S), else low.
REQ-023 SHALL apply mode only at the pop point; a change mid-frame takes effect next frame.
REQ-024 SHALL, on a simultaneous push and pop, perform both with count unchanged; with the FIFO empty, the pop underruns and the push is stored.
REQ-025 SHALL, when en=0, hold div_cnt=0 and bit_idx=0, and drive bck=0, ws=0, sdata=0 with no pulses; the FIFO still accepts data.
REQ-026 SHALL, when en rises, start the first frame with a pop on the first falling edge.
REQ-027 SHALL, when en falls mid-frame, abort the frame immediately; the popped frame is discarded.
REQ-028 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force bck=0, ws=0, sdata=0, frame_start=0, underrun=0, s_ready=0, and clear div_cnt, bit_idx and the FIFO.
REQ-030 SHALL, on the first clk after rst_n deasserts, drive s_ready=1.
REQ-031 SHALL, on reset mid-frame, discard the partial frame and buffered data.

Verification
REQ-032 SHALL cover: defaults, I2S mode, push L=0x800001, R=0x7FFFFF, en=1 -> sdata at slot0 bits 1..24 = 0x800001 MSB first and at slot1 bits 1..24 = 0x7FFFFF; ws rises at frame bit 31, falls at bit 63; other bits 0; bck period 4 clk.
REQ-033 SHALL cover: same data, mode=1 -> MSB at bits 0 and 32; ws rises at bit 32.
REQ-034 SHALL cover: en=1 with an empty FIFO -> an all-zero frame every 64 bck, and one underrun pulse per frame_start.
REQ-035 SHALL cover: push 4 frames with en=0 -> s_ready=0, and a 5th push is held; after en=1 and the first pop -> s_ready=1, and frames leave in order.
REQ-036 SHALL cover: NUM_CH=4, SLOT_W=32, push 0x111111, 0x222222, 0x333333, 0x444444 -> slots in ch0..ch3 order; ws is a 1-bck pulse at bit 127 (I2S).
REQ-037 SHALL cover: rst_n low at frame bit 40 -> all outputs 0 immediately; after release, s_ready=1 and the FIFO is empty (next frame underruns).
